// File: rtl/ca_tref_sequencer_pkg.sv
// Shared constants and FSM encoding for the neuron-state time-reference sequencer.
// Also used by the controller and the neuron SRAM wrapper.
package ca_tref_sequencer_pkg;

    localparam int CA_N_NEUR = 256;
    localparam int CA_ADDR_W = 8;
    localparam int CA_WORD_W = 128;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SW_RD = 3'd1;
    localparam logic [2:0] ST_SW_WB = 3'd2;
    localparam logic [2:0] ST_EV_RD = 3'd3;
    localparam logic [2:0] ST_EV_WB = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SW_RD = ST_SW_RD,
        SW_WB = ST_SW_WB,
        EV_RD = ST_EV_RD,
        EV_WB = ST_EV_WB
    } seq_state_e;

endpackage

// File: rtl/ca_tref_sequencer.sv
// Read-modify-write sequencer for the neuron SRAM: a time-reference sweep over all
// neurons interleaved with single spike-event updates, one event between sweep slots.
module ca_tref_sequencer
    import ca_tref_sequencer_pkg::*;
#(
    parameter int N_NEUR = CA_N_NEUR,
    parameter int ADDR_W = CA_ADDR_W,
    parameter int WORD_W = CA_WORD_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              tref_req,
    output logic              tref_busy,
    output logic              tref_done,
    output logic              tref_overrun,
    input  logic              evt_req,
    input  logic [ADDR_W-1:0] evt_addr,
    output logic              evt_ack,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic [WORD_W-1:0] dp_state,
    output logic              dp_event_tref,
    input  logic [WORD_W-1:0] dp_next
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;

    logic              last_nrn;
    logic              sweep_done;
    logic              cs_c, we_c, tref_c, done_c, ack_c;
    logic [ADDR_W-1:0] addr_c;

    // Explicit compare rather than counter overflow so non-power-of-2 sizes work.
    assign last_nrn   = (ptr_q == ADDR_W'(N_NEUR - 1));
    assign sweep_done = (state_q == SW_WB) && last_nrn;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (evt_req)        state_d = EV_RD;
                else if (pending_q) state_d = SW_RD;
            end
            SW_RD: state_d = SW_WB;
            SW_WB: begin
                ptr_d = last_nrn ? '0 : ptr_q + ADDR_W'(1);
                if (evt_req)       state_d = EV_RD;
                else if (last_nrn) state_d = IDLE;
                else               state_d = SW_RD;
            end
            EV_RD: state_d = EV_WB;
            EV_WB: state_d = pending_q ? SW_RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A request landing on the final write-back re-arms the sweep instead of overrunning.
    always_comb begin
        pending_d = pending_q;
        overrun_d = 1'b0;
        if (sweep_done) pending_d = 1'b0;
        if (tref_req) begin
            if (!pending_q || sweep_done) pending_d = 1'b1;
            else                          overrun_d = 1'b1;
        end
    end

    always_comb begin
        cs_c   = 1'b0;
        we_c   = 1'b0;
        tref_c = 1'b0;
        done_c = 1'b0;
        ack_c  = 1'b0;
        addr_c = '0;
        case (state_q)
            SW_RD: begin
                cs_c   = 1'b1;
                addr_c = ptr_q;
            end
            SW_WB: begin
                cs_c   = 1'b1;
                we_c   = 1'b1;
                tref_c = 1'b1;
                done_c = last_nrn;
                addr_c = ptr_q;
            end
            EV_RD: begin
                cs_c   = 1'b1;
                addr_c = evt_addr;
            end
            EV_WB: begin
                cs_c   = 1'b1;
                we_c   = 1'b1;
                ack_c  = 1'b1;
                addr_c = evt_addr;
            end
            default: ;
        endcase
    end

    // Outputs are forced low while reset is asserted so an in-flight write-back is dropped.
    assign sram_cs       = RSTN & cs_c;
    assign sram_we       = RSTN & we_c;
    assign sram_addr     = RSTN ? addr_c : '0;
    assign sram_wdata    = RSTN ? dp_next : '0;
    assign dp_state      = RSTN ? sram_rdata : '0;
    assign dp_event_tref = RSTN & tref_c;
    assign tref_done     = RSTN & done_c;
    assign evt_ack       = RSTN & ack_c;
    assign tref_busy     = RSTN & pending_q;
    assign tref_overrun  = RSTN & overrun_q;

endmodule

// File: tb/tb_ca_tref_sequencer.sv
// Bench for ca_tref_sequencer: SRAM and datapath models plus a write-back scoreboard.
module tb_ca_tref_sequencer;
    import ca_tref_sequencer_pkg::*;

    localparam int N  = 256;
    localparam int AW = 8;
    localparam int WW = 128;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          tref;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          tref_req;
    logic          tref_busy;
    logic          tref_done;
    logic          tref_overrun;
    logic          evt_req;
    logic [AW-1:0] evt_addr;
    logic          evt_ack;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [WW-1:0] sram_wdata;
    logic [WW-1:0] sram_rdata;
    logic [WW-1:0] dp_state;
    logic          dp_event_tref;
    logic [WW-1:0] dp_next;

    logic [WW-1:0] mem    [N];
    logic [WW-1:0] shadow [N];
    logic [WW-1:0] rdata_q;
    exp_t          exp_q  [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt, ack_cnt, ovr_cnt, wr_cnt;
    int done_cyc, ack_cyc, ovr_cyc, first_rd_cyc;
    logic arm_rd = 1'b0;

    ca_tref_sequencer #(.N_NEUR(N), .ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .tref_req     (tref_req),
        .tref_busy    (tref_busy),
        .tref_done    (tref_done),
        .tref_overrun (tref_overrun),
        .evt_req      (evt_req),
        .evt_addr     (evt_addr),
        .evt_ack      (evt_ack),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .dp_state     (dp_state),
        .dp_event_tref(dp_event_tref),
        .dp_next      (dp_next)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Stand-in for the LIF/calcium datapath: distinct updates for sweep and event.
    function automatic logic [WW-1:0] dp_model(input logic [WW-1:0] s, input logic t);
        return t ? s + 128'd1 : ({s[WW-2:0], s[WW-1]} ^ 128'hA5);
    endfunction

    assign dp_next    = dp_model(dp_state, dp_event_tref);
    assign sram_rdata = rdata_q;

    always @(posedge CLK) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] = sram_wdata;
            else         rdata_q <= mem[sram_addr];
        end
    end

    // Every write-back is matched against the next expected (address, flag) and the
    // shadow-memory value, which advances by the datapath model.
    always @(negedge CLK) begin
        exp_t          e;
        logic [WW-1:0] want;
        if (sram_cs && !sram_we && arm_rd) begin
            first_rd_cyc = cyc;
            arm_rd = 1'b0;
        end
        if (tref_done)    begin done_cnt++; done_cyc = cyc; end
        if (evt_ack)      begin ack_cnt++;  ack_cyc  = cyc; end
        if (tref_overrun) begin ovr_cnt++;  ovr_cyc  = cyc; end
        if (sram_cs && sram_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h tref %0b, expected no write", sram_addr, dp_event_tref);
            end else begin
                e = exp_q.pop_front();
                if ({sram_addr, dp_event_tref, evt_ack} !== {e.addr, e.tref, ~e.tref}) begin
                    errors++;
                    $display("[TB] FAIL wb_addr_flag: got addr %0h tref %0b ack %0b, expected addr %0h tref %0b ack %0b",
                             sram_addr, dp_event_tref, evt_ack, e.addr, e.tref, ~e.tref);
                end
                want = dp_model(shadow[e.addr], e.tref);
                checks++;
                if (sram_wdata !== want) begin
                    errors++;
                    $display("[TB] FAIL wb_data: got %h, expected %h", sram_wdata, want);
                end
                shadow[e.addr] = want;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_counts();
        done_cnt = 0; ack_cnt = 0; ovr_cnt = 0; wr_cnt = 0;
        done_cyc = -1; ack_cyc = -1; ovr_cyc = -1; first_rd_cyc = -1;
    endtask

    task automatic push_sweep(input int upto);
        for (int a = 0; a < upto; a++) exp_q.push_back(exp_t'{addr: AW'(a), tref: 1'b1});
    endtask

    task automatic pulse_tref();
        tref_req = 1'b1;
        tick();
        tref_req = 1'b0;
    endtask

    task automatic wait_done(input int want, input int budget);
        for (int i = 0; i < budget && done_cnt < want; i++) tick();
        checks++;
        if (done_cnt !== want) begin
            errors++;
            $display("[TB] FAIL done_wait: got %0d tref_done pulses, expected %0d", done_cnt, want);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained: got %0d writes outstanding, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        RSTN = 1'b0; tref_req = 1'b0; evt_req = 1'b0; evt_addr = '0;
        repeat (3) tick();
        @(negedge CLK);
        checks++;
        if ({sram_cs, sram_we, tref_busy, tref_done, tref_overrun, evt_ack, dp_event_tref} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 0000000",
                     {sram_cs, sram_we, tref_busy, tref_done, tref_overrun, evt_ack, dp_event_tref});
        end
        checks++;
        if (sram_addr !== '0 || sram_wdata !== '0 || dp_state !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr %h wdata %h state %h, expected all 0", sram_addr, sram_wdata, dp_state);
        end
        tick();
        RSTN = 1'b1;
        repeat (2) tick();
        @(negedge CLK);
        checks++;
        if ({sram_cs, tref_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_idle: got cs %0b busy %0b, expected 0 0", sram_cs, tref_busy);
        end
        tick();
    endtask

    task automatic test_single_event();
        int t0;
        clear_counts();
        exp_q.push_back(exp_t'{addr: 8'h2A, tref: 1'b0});
        evt_addr = 8'h2A;
        evt_req  = 1'b1;
        t0 = cyc;
        tick();
        @(negedge CLK);
        checks++;
        if ({sram_cs, sram_we, sram_addr} !== {2'b10, 8'h2A}) begin
            errors++;
            $display("[TB] FAIL event_read: got cs %0b we %0b addr %h, expected 1 0 2a", sram_cs, sram_we, sram_addr);
        end
        for (int i = 0; i < 10 && ack_cnt == 0; i++) tick();
        evt_req = 1'b0;
        checks++;
        if (ack_cyc - t0 !== 2) begin
            errors++;
            $display("[TB] FAIL event_latency: got %0d cycles, expected 2", ack_cyc - t0);
        end
        repeat (3) tick();
        checks++;
        if (mem[8'h2A] !== shadow[8'h2A] || ack_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL event_sram: got %h acks %0d, expected %h acks 1", mem[8'h2A], ack_cnt, shadow[8'h2A]);
        end
        check_drained("single_event");
    endtask

    task automatic test_sweep();
        clear_counts();
        push_sweep(N);
        arm_rd = 1'b1;
        pulse_tref();
        wait_done(1, 2000);
        repeat (3) tick();
        checks++;
        if (wr_cnt !== N) begin
            errors++;
            $display("[TB] FAIL sweep_writes: got %0d, expected %0d", wr_cnt, N);
        end
        // The sweep occupies 2*N cycles: first SW_RD through the final write-back.
        checks++;
        if (done_cyc - first_rd_cyc !== 2 * N - 1) begin
            errors++;
            $display("[TB] FAIL sweep_latency: got %0d, expected %0d", done_cyc - first_rd_cyc, 2 * N - 1);
        end
        checks++;
        if (tref_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sweep_busy: got %0b, expected 0", tref_busy);
        end
        check_drained("sweep");
    endtask

    task automatic test_event_during_sweep();
        clear_counts();
        exp_q.push_back(exp_t'{addr: 8'h10, tref: 1'b0});
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(exp_t'{addr: AW'(k), tref: 1'b1});
            exp_q.push_back(exp_t'{addr: 8'h10, tref: 1'b0});
        end
        evt_addr = 8'h10;
        evt_req  = 1'b1;
        pulse_tref();
        for (int i = 0; i < 3000 && ack_cnt < N + 1; i++) tick();
        evt_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (ack_cnt !== N + 1) begin
            errors++;
            $display("[TB] FAIL interleave_acks: got %0d, expected %0d", ack_cnt, N + 1);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL interleave_done: got %0d, expected 1", done_cnt);
        end
        check_drained("interleave");
    endtask

    task automatic test_overrun();
        int   t_req;
        logic found = 1'b0;
        clear_counts();
        push_sweep(N);
        pulse_tref();
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge CLK);
            if (sram_we && sram_addr == 8'd100) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL overrun_reach100: got no write to 100, expected one");
        end
        tick();
        tref_req = 1'b1;
        t_req = cyc;
        tick();
        tref_req = 1'b0;
        wait_done(1, 1000);
        repeat (20) tick();
        checks++;
        if (ovr_cnt !== 1 || ovr_cyc !== t_req + 1) begin
            errors++;
            $display("[TB] FAIL overrun_pulse: got %0d pulses at %0d, expected 1 at %0d", ovr_cnt, ovr_cyc, t_req + 1);
        end
        checks++;
        if (done_cnt !== 1 || wr_cnt !== N || tref_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_single_sweep: got done %0d writes %0d busy %0b, expected 1 %0d 0",
                     done_cnt, wr_cnt, tref_busy, N);
        end
        check_drained("overrun");
    endtask

    task automatic test_back_to_back();
        int   t_done = -1;
        logic found = 1'b0;
        clear_counts();
        push_sweep(N);
        pulse_tref();
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge CLK);
            if (sram_we && sram_addr == AW'(N - 1)) found = 1'b1;
        end
        push_sweep(N);
        tref_req = 1'b1;
        t_done = cyc;
        tick();
        tref_req = 1'b0;
        checks++;
        if (!found || done_cnt !== 1 || done_cyc !== t_done) begin
            errors++;
            $display("[TB] FAIL b2b_first_done: got found %0b done %0d at %0d, expected 1 1 at %0d",
                     found, done_cnt, done_cyc, t_done);
        end
        @(negedge CLK);
        checks++;
        if ({tref_busy, tref_overrun} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_busy: got busy %0b overrun %0b, expected 1 0", tref_busy, tref_overrun);
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (sram_cs) found = 1'b1;
            else @(negedge CLK);
        end
        checks++;
        if (!found || {sram_we, sram_addr} !== {1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got found %0b we %0b addr %h, expected 1 0 00", found, sram_we, sram_addr);
        end
        wait_done(2, 1000);
        repeat (3) tick();
        checks++;
        if (wr_cnt !== 2 * N || tref_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_total: got writes %0d busy %0b, expected %0d 0", wr_cnt, tref_busy, 2 * N);
        end
        check_drained("b2b");
    endtask

    task automatic test_reset_mid_sweep();
        logic found = 1'b0;
        clear_counts();
        push_sweep(50);
        pulse_tref();
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge CLK);
            if (sram_cs && !sram_we && sram_addr == 8'd50) found = 1'b1;
        end
        tick();
        RSTN = 1'b0;
        @(negedge CLK);
        checks++;
        if (!found || {sram_cs, sram_we, tref_busy, tref_done, evt_ack, dp_event_tref} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got found %0b ctrl %b, expected 1 000000",
                     found, {sram_cs, sram_we, tref_busy, tref_done, evt_ack, dp_event_tref});
        end
        checks++;
        if (sram_addr !== '0 || sram_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_data: got addr %h wdata %h, expected 0 0", sram_addr, sram_wdata);
        end
        tick();
        RSTN = 1'b1;
        repeat (10) tick();
        checks++;
        if (done_cnt !== 0 || wr_cnt !== 50 || tref_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_abort: got done %0d writes %0d busy %0b, expected 0 50 0", done_cnt, wr_cnt, tref_busy);
        end
        check_drained("midreset_abort");
        clear_counts();
        push_sweep(N);
        pulse_tref();
        wait_done(1, 2000);
        repeat (3) tick();
        checks++;
        if (wr_cnt !== N) begin
            errors++;
            $display("[TB] FAIL midreset_resweep: got %0d writes, expected %0d", wr_cnt, N);
        end
        check_drained("midreset_resweep");
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i] = {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hDEADBEEF, 32'(i + 7), 32'hC0FFEE00 | 32'(i)};
            shadow[i] = mem[i];
        end
        rdata_q = '0;
        clear_counts();
        test_reset();
        test_single_event();
        test_sweep();
        test_event_during_sweep();
        test_overrun();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
